// File: rtl/fnd_scan_ctrl.sv
// fnd_scan_ctrl: 4-digit multiplexed 7-segment (FND) display controller.
// A binary value arrives through a single-cycle load request. It is converted
// to BCD by shift-add-3 over BIN_W cycles, and all digits are then committed
// to the display registers together. The shared active-low segment lines are
// time-multiplexed across the active-low digit commons. Each digit stays
// enabled for SCAN_DIV clocks.
// Optional feature macro: FND_LZB_EN (leading-zero blanking of upper digits).
// Timing: load sampled at edge E0 -> busy high after E0+1, new display
// registers and busy low after E0+BIN_W+2. busy is high for BIN_W+1 cycles.

module fnd_scan_ctrl #(
  parameter int N_DIGITS = 4,
  parameter int SCAN_DIV = 50000,
  parameter int BIN_W    = 14
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [BIN_W-1:0]    bin_in,
  output logic                busy,
  output logic [6:0]          seg,
  output logic [N_DIGITS-1:0] com
);

  localparam int PW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW    = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam int IW    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int BCD_W = 4 * N_DIGITS;

  localparam logic [BIN_W-1:0] MAX_VAL   = BIN_W'(9999);
  localparam logic [PW-1:0]    PRESC_TOP = PW'(SCAN_DIV - 1);
  localparam logic [CW-1:0]    CNT_TOP   = CW'(BIN_W - 1);
  localparam logic [IW-1:0]    IDX_TOP   = IW'(N_DIGITS - 1);
  localparam logic [6:0]       SEG_OFF   = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // Decimal digit to active-low {g,f,e,d,c,b,a}. Non-decimal nibbles stay dark.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0011000;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t              state_q, state_d;
  logic                load_q, load_d;     // accepted request, one cycle
  logic [BIN_W-1:0]    bin_q, bin_d;       // saturated captured value
  logic [BIN_W-1:0]    sh_q, sh_d;         // binary shift register
  logic [BCD_W-1:0]    bcd_q, bcd_d;       // BCD accumulator
  logic [CW-1:0]       cnt_q, cnt_d;       // conversion step counter
  logic                busy_q, busy_d;
  logic [BCD_W-1:0]    disp_q, disp_d;     // committed display digits
  logic [PW-1:0]       presc_q, presc_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [6:0]          seg_q, seg_d;
  logic [N_DIGITS-1:0] com_q, com_d;

  logic                accept;
  logic [BCD_W-1:0]    bcd_adj;
  logic [3:0]          cur_digit;
  logic [N_DIGITS-1:0] blank;

  // Request capture: a load is taken only when nothing is in flight, so a
  // load while busy is dropped rather than queued.
  always_comb begin
    // NOTE: every signal driven here gets a default first so that no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    accept = load && !busy_q && !load_q;
    load_d = accept;
    bin_d  = bin_q;
    if (accept) begin
      bin_d = (bin_in > MAX_VAL) ? MAX_VAL : bin_in;
    end
  end

  // Conversion FSM: next-state, shift-add-3 datapath and commit.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    bcd_adj = bcd_q;

    for (int i = 0; i < N_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end

    case (state_q)
      IDLE: begin
        if (load_q) begin
          sh_d    = bin_q;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        bcd_d = {bcd_adj[BCD_W-2:0], sh_q[BIN_W-1]};
        sh_d  = {sh_q[BIN_W-2:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_TOP) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        // All digits change together; partial results never reach the display.
        disp_d  = bcd_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // Scan timing: prescaler wraps at SCAN_DIV-1 and steps the digit index.
  // A commit does not disturb this; the new value simply appears on the
  // digit currently being scanned.
  always_comb begin
    presc_d = presc_q + 1'b1;
    idx_d   = idx_q;
    if (presc_q == PRESC_TOP) begin
      presc_d = '0;
      idx_d   = (idx_q == IDX_TOP) ? '0 : idx_q + 1'b1;
    end
  end

  // Leading-zero blanking: a digit goes dark when it and every higher digit
  // are zero. The units digit always shows.
`ifdef FND_LZB_EN
  always_comb begin
    blank = '0;
    for (int i = N_DIGITS - 1; i > 0; i--) begin
      if (i == N_DIGITS - 1) begin
        blank[i] = (disp_q[4*i +: 4] == 4'd0);
      end else begin
        blank[i] = blank[i+1] && (disp_q[4*i +: 4] == 4'd0);
      end
    end
  end
`else
  assign blank = '0;
`endif

  // Output decode for the digit selected by the current scan index.
  always_comb begin
    cur_digit = disp_q[4*idx_q +: 4];
    seg_d     = blank[idx_q] ? SEG_OFF : seg_decode(cur_digit);
    com_d     = ~(N_DIGITS'(1) << idx_q);
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= IDLE;
      load_q  <= 1'b0;
      bin_q   <= '0;
      sh_q    <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      // NOTE: the display registers are reset on purpose: after reset the
      // display must read 0, even if a conversion was in progress.
      disp_q  <= '0;
      presc_q <= '0;
      idx_q   <= '0;
      seg_q   <= SEG_OFF;
      com_q   <= '1;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
      bin_q   <= bin_d;
      sh_q    <= sh_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      disp_q  <= disp_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      com_q   <= com_d;
    end
  end

  assign busy = busy_q;
  assign seg  = seg_q;
  assign com  = com_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Self-checking bench for fnd_scan_ctrl (SCAN_DIV=4). Expected digit patterns
// are pushed to a scoreboard queue when a load is driven. They are popped and
// compared when the scan shows the committed value.
// The leading-zero expectations follow FND_LZB_EN.

module tb_fnd_scan_ctrl;

  localparam int BIN_W    = 14;
  localparam int SCAN_DIV = 4;

  logic             clk;
  logic             rst;
  logic             load;
  logic [BIN_W-1:0] bin_in;
  logic             busy;
  logic [6:0]       seg;
  logic [3:0]       com;

  int checks   = 0;
  int failures = 0;

  logic [6:0] exp_q[$];

  fnd_scan_ctrl #(
    .N_DIGITS(4),
    .SCAN_DIV(SCAN_DIV),
    .BIN_W   (BIN_W)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .bin_in(bin_in),
    .busy  (busy),
    .seg   (seg),
    .com   (com)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [6:0] digit_pattern(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0011000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Scoreboard producer: expected segments for digits 0..3 of value v.
  task automatic push_expected(input int v);
    int pw[4] = '{1, 10, 100, 1000};
    int s;
    bit blank;
    s = (v > 9999) ? 9999 : v;
    for (int i = 0; i < 4; i++) begin
      blank = 1'b0;
`ifdef FND_LZB_EN
      blank = (i > 0) && (s < pw[i]);
`endif
      exp_q.push_back(blank ? 7'b1111111 : digit_pattern((s / pw[i]) % 10));
    end
  endtask

  // Drive a one-cycle load; returns at the negedge after the sampling edge.
  task automatic do_load(input int v, input bit push);
    @(negedge clk);
    load   = 1'b1;
    bin_in = BIN_W'(v);
    if (push) push_expected(v);
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
  endtask

  // Bounded wait for a conversion to start and finish.
  task automatic wait_idle(output bit ok);
    int n;
    ok = 1'b1;
    n  = 0;
    while (busy !== 1'b1 && n < 6) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b1) ok = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) ok = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Observe the segment pattern shown while each digit common is enabled.
  task automatic capture_digits(output logic [27:0] obs, output bit ok);
    logic [3:0] want;
    int n;
    ok  = 1'b1;
    obs = '1;
    for (int d = 0; d < 4; d++) begin
      want = ~(4'(1) << d);
      n = 0;
      while (com !== want && n < 64) begin
        @(negedge clk);
        n++;
      end
      if (com !== want) ok = 1'b0;
      obs[d*7 +: 7] = seg;
    end
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    load   = 1'b0;
    bin_in = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (seg !== 7'b1111111) begin
      failures++;
      $display("FAIL reset_seg got=%b want=%b", seg, 7'b1111111);
    end
    checks++;
    if (com !== 4'b1111) begin
      failures++;
      $display("FAIL reset_com got=%b want=%b", com, 4'b1111);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy got=%b want=0", busy);
    end
    rst = 1'b0;
  endtask

  // Right after reset release: each common held SCAN_DIV cycles, all digits 0.
  task automatic test_idle_scan();
    logic [3:0] want;
    logic [6:0] exp_seg;
    int run;
    exp_seg = 7'b1000000;
`ifdef FND_LZB_EN
    exp_seg = 7'b1111111;
`endif
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      want = ~(4'(1) << k);
      checks++;
      if (com !== want) begin
        failures++;
        $display("FAIL idle_com%0d got=%b want=%b", k, com, want);
      end
      checks++;
      if (seg !== ((k == 0) ? 7'b1000000 : exp_seg)) begin
        failures++;
        $display("FAIL idle_seg%0d got=%b want=%b", k, seg,
                 (k == 0) ? 7'b1000000 : exp_seg);
      end
      run = 0;
      while (com === want && run < 20) begin
        run++;
        @(negedge clk);
      end
      checks++;
      if (run != SCAN_DIV) begin
        failures++;
        $display("FAIL idle_hold%0d got=%0d want=%0d", k, run, SCAN_DIV);
      end
    end
  endtask

  task automatic test_load_1234();
    int n, hi, fall;
    logic [27:0] obs;
    logic [6:0] e;
    bit ok;
    do_load(1234, 1'b1);
    n = 1; hi = 0; fall = 0;
    while (n < 60 && fall == 0) begin
      if (busy === 1'b1) hi++;
      else if (hi > 0) fall = n;
      if (fall == 0) begin
        @(negedge clk);
        n++;
      end
    end
    checks++;
    if (hi != BIN_W + 1) begin
      failures++;
      $display("FAIL load1234_busy_len got=%0d want=%0d", hi, BIN_W + 1);
    end
    checks++;
    if (fall - 1 != BIN_W + 2) begin
      failures++;
      $display("FAIL load1234_latency got=%0d want=%0d", fall - 1, BIN_W + 2);
    end
    repeat (2) @(negedge clk);
    capture_digits(obs, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL load1234_scan_timeout got=0 want=1");
    end
    for (int d = 0; d < 4; d++) begin
      e = exp_q.pop_front();
      checks++;
      if (obs[d*7 +: 7] !== e) begin
        failures++;
        $display("FAIL load1234_digit%0d got=%b want=%b", d, obs[d*7 +: 7], e);
      end
    end
  endtask

  task automatic test_saturate();
    logic [27:0] obs;
    logic [6:0] e;
    bit ok, ok2;
    do_load(12000, 1'b1);
    wait_idle(ok);
    capture_digits(obs, ok2);
    checks++;
    if (!(ok && ok2)) begin
      failures++;
      $display("FAIL sat_timeout got=0 want=1");
    end
    for (int d = 0; d < 4; d++) begin
      e = exp_q.pop_front();
      checks++;
      if (obs[d*7 +: 7] !== e) begin
        failures++;
        $display("FAIL sat_digit%0d got=%b want=%b", d, obs[d*7 +: 7], e);
      end
    end
  endtask

  task automatic test_ignore_busy();
    logic [27:0] obs;
    logic [6:0] e;
    bit ok, ok2;
    do_load(1234, 1'b1);
    repeat (3) @(negedge clk);
    do_load(5678, 1'b0);
    wait_idle(ok);
    // A restarted or queued conversion would raise busy again here.
    repeat (20) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL ignore_busy_again got=%b want=0", busy);
    end
    capture_digits(obs, ok2);
    checks++;
    if (!(ok && ok2)) begin
      failures++;
      $display("FAIL ignore_timeout got=0 want=1");
    end
    for (int d = 0; d < 4; d++) begin
      e = exp_q.pop_front();
      checks++;
      if (obs[d*7 +: 7] !== e) begin
        failures++;
        $display("FAIL ignore_digit%0d got=%b want=%b", d, obs[d*7 +: 7], e);
      end
    end
  endtask

  task automatic test_reset_abort();
    logic [27:0] obs;
    logic [6:0] e;
    bit ok, seen;
    do_load(9999, 1'b0);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    push_expected(0);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_busy got=%b want=0", busy);
    end
    checks++;
    if (com !== 4'b1111) begin
      failures++;
      $display("FAIL abort_com got=%b want=%b", com, 4'b1111);
    end
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (busy === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL abort_late_busy got=1 want=0");
    end
    capture_digits(obs, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL abort_timeout got=0 want=1");
    end
    for (int d = 0; d < 4; d++) begin
      e = exp_q.pop_front();
      checks++;
      if (obs[d*7 +: 7] !== e) begin
        failures++;
        $display("FAIL abort_digit%0d got=%b want=%b", d, obs[d*7 +: 7], e);
      end
    end
  endtask

  task automatic test_load_7();
    logic [27:0] obs;
    logic [6:0] e;
    bit ok, ok2;
    do_load(7, 1'b1);
    wait_idle(ok);
    capture_digits(obs, ok2);
    checks++;
    if (!(ok && ok2)) begin
      failures++;
      $display("FAIL load7_timeout got=0 want=1");
    end
    for (int d = 0; d < 4; d++) begin
      e = exp_q.pop_front();
      checks++;
      if (obs[d*7 +: 7] !== e) begin
        failures++;
        $display("FAIL load7_digit%0d got=%b want=%b", d, obs[d*7 +: 7], e);
      end
    end
  endtask

  // Second load issued as soon as the first completes; it must be accepted.
  task automatic test_back_to_back();
    logic [27:0] obs;
    logic [6:0] e;
    bit ok, ok2, ok3;
    do_load(42, 1'b0);
    wait_idle(ok);
    do_load(805, 1'b1);
    wait_idle(ok2);
    capture_digits(obs, ok3);
    checks++;
    if (!(ok && ok2 && ok3)) begin
      failures++;
      $display("FAIL b2b_timeout got=0 want=1");
    end
    for (int d = 0; d < 4; d++) begin
      e = exp_q.pop_front();
      checks++;
      if (obs[d*7 +: 7] !== e) begin
        failures++;
        $display("FAIL b2b_digit%0d got=%b want=%b", d, obs[d*7 +: 7], e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_load_1234();
    test_saturate();
    test_ignore_busy();
    test_reset_abort();
    test_load_7();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
